// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: six-state one-hot ring (T1..T6) with opcode decode in T4..T6.
// Define SAP1_EARLY_END_EN to skip trailing T-states that carry no strobes.
module sap1_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  output logic [5:0] tstate,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_load,
  output logic       halted
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

`ifdef SAP1_EARLY_END_EN
  localparam logic EARLY_END = 1'b1;
`else
  localparam logic EARLY_END = 1'b0;
`endif

  typedef enum logic [5:0] {
    ST_HALT = 6'b000000,
    ST_T1   = 6'b000001,
    ST_T2   = 6'b000010,
    ST_T3   = 6'b000100,
    ST_T4   = 6'b001000,
    ST_T5   = 6'b010000,
    ST_T6   = 6'b100000
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic pc_inc_s, pc_out_s, mar_load_s, ram_out_s, ir_load_s, ir_out_s;
  logic a_load_s, a_out_s, b_load_s, alu_out_s, alu_sub_s, out_load_s;

  // Ring state register; the halt state is only left through reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_T1;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and strobe decode from the current T-state and opcode.
  always_comb begin
    state_next_s = state_r;
    pc_inc_s   = 1'b0;
    pc_out_s   = 1'b0;
    mar_load_s = 1'b0;
    ram_out_s  = 1'b0;
    ir_load_s  = 1'b0;
    ir_out_s   = 1'b0;
    a_load_s   = 1'b0;
    a_out_s    = 1'b0;
    b_load_s   = 1'b0;
    alu_out_s  = 1'b0;
    alu_sub_s  = 1'b0;
    out_load_s = 1'b0;
    case (state_r)
      ST_T1: begin
        pc_out_s     = 1'b1;
        mar_load_s   = 1'b1;
        state_next_s = ST_T2;
      end
      ST_T2: begin
        pc_inc_s     = 1'b1;
        state_next_s = ST_T3;
      end
      ST_T3: begin
        ram_out_s    = 1'b1;
        ir_load_s    = 1'b1;
        state_next_s = ST_T4;
      end
      ST_T4: begin
        state_next_s = ST_T5;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ir_out_s   = 1'b1;
            mar_load_s = 1'b1;
          end
          OP_OUT: begin
            a_out_s    = 1'b1;
            out_load_s = 1'b1;
            if (EARLY_END) begin
              state_next_s = ST_T1;
            end else begin
              state_next_s = ST_T5;
            end
          end
          OP_HLT: begin
            state_next_s = ST_HALT;
          end
          default: begin
            // Undefined opcodes execute as NOP
            if (EARLY_END) begin
              state_next_s = ST_T1;
            end else begin
              state_next_s = ST_T5;
            end
          end
        endcase
      end
      ST_T5: begin
        state_next_s = ST_T6;
        case (opcode)
          OP_LDA: begin
            ram_out_s = 1'b1;
            a_load_s  = 1'b1;
            if (EARLY_END) begin
              state_next_s = ST_T1;
            end else begin
              state_next_s = ST_T6;
            end
          end
          OP_ADD: begin
            ram_out_s = 1'b1;
            b_load_s  = 1'b1;
          end
          OP_SUB: begin
            ram_out_s = 1'b1;
            b_load_s  = 1'b1;
            alu_sub_s = 1'b1;
          end
          default: begin
            state_next_s = ST_T6;
          end
        endcase
      end
      ST_T6: begin
        state_next_s = ST_T1;
        case (opcode)
          OP_ADD: begin
            alu_out_s = 1'b1;
            a_load_s  = 1'b1;
          end
          OP_SUB: begin
            alu_out_s = 1'b1;
            a_load_s  = 1'b1;
            alu_sub_s = 1'b1;
          end
          default: begin
            state_next_s = ST_T1;
          end
        endcase
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_T1;
      end
    endcase
  end

  // Strobes are gated by reset so nothing fires while reset is held low.
  assign pc_inc   = pc_inc_s   & reset;
  assign pc_out   = pc_out_s   & reset;
  assign mar_load = mar_load_s & reset;
  assign ram_out  = ram_out_s  & reset;
  assign ir_load  = ir_load_s  & reset;
  assign ir_out   = ir_out_s   & reset;
  assign a_load   = a_load_s   & reset;
  assign a_out    = a_out_s    & reset;
  assign b_load   = b_load_s   & reset;
  assign alu_out  = alu_out_s  & reset;
  assign alu_sub  = alu_sub_s  & reset;
  assign out_load = out_load_s & reset;
  assign tstate   = state_r;
  assign halted   = (state_r == ST_HALT);

endmodule
